// File: rtl/fp_pkg.sv
// Shared constants, flag layout and special-value helpers for the floating-point add/sub pipeline.
package fp_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;
  localparam int unsigned W_DEF     = 1 + EXP_W_DEF + MAN_W_DEF;

  localparam int unsigned FLAG_W         = 4;
  localparam int unsigned FLAG_INVALID   = 3;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_INEXACT   = 0;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  // Exponent field 0 is treated as zero: subnormals are flushed.
  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic man_zero);
    if (exp_zero) return CLS_ZERO;
    if (!exp_ones) return CLS_NORM;
    return man_zero ? CLS_INF : CLS_NAN;
  endfunction

  // Canonical quiet NaN {0, all-ones exponent, 1 followed by zeros}, right-aligned in 64 bits.
  function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
    return (((64'(1) << exp_w) - 64'(1)) << man_w) | (64'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle of the floating-point add/sub pipeline.
interface fp_addsub_pipe_if #(
  parameter int unsigned W = fp_pkg::W_DEF
);
  logic                      in_valid;
  logic                      in_ready;
  logic [W-1:0]              a_operand;
  logic [W-1:0]              b_operand;
  logic                      AddBar_Sub;
  logic                      out_valid;
  logic                      out_ready;
  logic [W-1:0]              result;
  logic                      Exception;
  logic [fp_pkg::FLAG_W-1:0] flags;

  modport master (
    output in_valid, a_operand, b_operand, AddBar_Sub, out_ready,
    input  in_ready, out_valid, result, Exception, flags
  );

  modport slave (
    input  in_valid, a_operand, b_operand, AddBar_Sub, out_ready,
    output in_ready, out_valid, result, Exception, flags
  );
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
  parameter  int unsigned WIDTH = 25,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] cnt_c
);

  // Ascending scan: the highest set bit is the last to write.
  always_comb begin
    cnt_c = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt_c = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor: align, add, normalise/round, with a stall-all handshake.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input logic             CLK,
  input logic             RESET_N,
  fp_addsub_pipe_if.slave bus
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W = MAN_W + 4;
  localparam int unsigned SUM_W = MAN_W + 5;
  localparam int unsigned LZC_W = MAN_W + 2;
  localparam int unsigned CNT_W = $clog2(LZC_W + 1);
  localparam int unsigned XE_W  = ((EXP_W > CNT_W) ? EXP_W : CNT_W) + 2;
  localparam logic [XE_W-1:0] EXP_MAX = XE_W'({EXP_W{1'b1}});
  localparam logic [W-1:0]    QNAN    = W'(fp_qnan(EXP_W, MAN_W));

  logic stall;
  logic adv;

  assign stall        = bus.out_valid && !bus.out_ready;
  assign adv          = !stall;
  assign bus.in_ready = adv;

  logic                   a_sign, b_sign, l_sign;
  logic [EXP_W-1:0]       a_exp, b_exp, l_exp, s_exp, exp_diff;
  logic [MAN_W-1:0]       a_man, b_man;
  logic [EXP_W+MAN_W-1:0] a_mag, b_mag;
  fp_class_e              a_cls, b_cls;
  logic                   eff_sub, swap, nan_in, inf_inf, special;
  logic [SIG_W-1:0]       l_sig, s_ext, s_mask, s_al;
  logic [W-1:0]           spec_val;
  logic [FLAG_W-1:0]      spec_flags;

  // S1: unpack, order by magnitude, align smaller significand with guard/round/sticky.
  always_comb begin
    a_sign  = bus.a_operand[W-1];
    b_sign  = bus.b_operand[W-1] ^ bus.AddBar_Sub;
    a_exp   = bus.a_operand[W-2 -: EXP_W];
    b_exp   = bus.b_operand[W-2 -: EXP_W];
    a_man   = (a_exp == '0) ? '0 : bus.a_operand[MAN_W-1:0];
    b_man   = (b_exp == '0) ? '0 : bus.b_operand[MAN_W-1:0];
    a_cls   = fp_classify(a_exp == '0, &a_exp, a_man == '0);
    b_cls   = fp_classify(b_exp == '0, &b_exp, b_man == '0);
    a_mag   = {a_exp, a_man};
    b_mag   = {b_exp, b_man};
    swap    = b_mag > a_mag;
    eff_sub = a_sign ^ b_sign;
    l_sign  = swap ? b_sign : a_sign;
    l_exp   = swap ? b_exp : a_exp;
    s_exp   = swap ? a_exp : b_exp;
    l_sig   = swap ? {(b_exp != '0), b_man, 3'b000} : {(a_exp != '0), a_man, 3'b000};
    s_ext   = swap ? {(a_exp != '0), a_man, 3'b000} : {(b_exp != '0), b_man, 3'b000};

    // Shifts at or beyond SIG_W leave an empty mask complement, so everything lands in sticky.
    exp_diff = l_exp - s_exp;
    s_mask   = ~({SIG_W{1'b1}} << exp_diff);
    s_al     = (s_ext >> exp_diff) | SIG_W'(|(s_ext & s_mask));

    nan_in  = (a_cls == CLS_NAN) || (b_cls == CLS_NAN);
    inf_inf = (a_cls == CLS_INF) && (b_cls == CLS_INF) && eff_sub;
    special = nan_in || (a_cls == CLS_INF) || (b_cls == CLS_INF);

    spec_flags               = '0;
    spec_flags[FLAG_INVALID] = nan_in || inf_inf;
    if (nan_in || inf_inf)      spec_val = QNAN;
    else if (a_cls == CLS_INF)  spec_val = {a_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else                        spec_val = {b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  logic              s1_valid, s1_special, s1_sign, s1_eff_sub;
  logic [W-1:0]      s1_spec_val;
  logic [FLAG_W-1:0] s1_spec_flags;
  logic [EXP_W-1:0]  s1_exp;
  logic [SIG_W-1:0]  s1_l_sig, s1_s_al;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_valid      <= 1'b0;
      s1_special    <= 1'b0;
      s1_sign       <= 1'b0;
      s1_eff_sub    <= 1'b0;
      s1_spec_val   <= '0;
      s1_spec_flags <= '0;
      s1_exp        <= '0;
      s1_l_sig      <= '0;
      s1_s_al       <= '0;
    end else if (adv) begin
      s1_valid      <= bus.in_valid;
      s1_special    <= special;
      s1_sign       <= l_sign;
      s1_eff_sub    <= eff_sub;
      s1_spec_val   <= spec_val;
      s1_spec_flags <= spec_flags;
      s1_exp        <= l_exp;
      s1_l_sig      <= l_sig;
      s1_s_al       <= s_al;
    end
  end

  logic              s2_valid, s2_special, s2_sign, s2_eff_sub;
  logic [W-1:0]      s2_spec_val;
  logic [FLAG_W-1:0] s2_spec_flags;
  logic [EXP_W-1:0]  s2_exp;
  logic [SUM_W-1:0]  s2_sum;

  // S2: magnitude add or subtract; the larger operand is always first so no borrow out.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s2_valid      <= 1'b0;
      s2_special    <= 1'b0;
      s2_sign       <= 1'b0;
      s2_eff_sub    <= 1'b0;
      s2_spec_val   <= '0;
      s2_spec_flags <= '0;
      s2_exp        <= '0;
      s2_sum        <= '0;
    end else if (adv) begin
      s2_valid      <= s1_valid;
      s2_special    <= s1_special;
      s2_sign       <= s1_sign;
      s2_eff_sub    <= s1_eff_sub;
      s2_spec_val   <= s1_spec_val;
      s2_spec_flags <= s1_spec_flags;
      s2_exp        <= s1_exp;
      s2_sum        <= s1_eff_sub ? ({1'b0, s1_l_sig} - {1'b0, s1_s_al})
                                  : ({1'b0, s1_l_sig} + {1'b0, s1_s_al});
    end
  end

  logic              carry, sum_zero, g_bit, r_bit, s_bit, rnd_up, uf, of;
  logic [CNT_W-1:0]  lzc;
  logic [SIG_W-1:0]  norm;
  logic [MAN_W:0]    m;
  logic [MAN_W+1:0]  m_r;
  logic [XE_W-1:0]   exp_x, exp_r;
  logic [W-1:0]      res3;
  logic [FLAG_W-1:0] flags3;

  // Leading one can only sit in hidden..guard; deeper cancellation is always exact.
  fp_lzc #(.WIDTH(LZC_W)) u_lzc (
    .din   (s2_sum[SIG_W-1 -: LZC_W]),
    .cnt_c (lzc)
  );

  // S3: normalise, round-to-nearest-even, classify overflow/underflow.
  always_comb begin
    carry    = s2_sum[SUM_W-1];
    sum_zero = (s2_sum == '0);
    norm     = carry ? {s2_sum[SUM_W-1:2], |s2_sum[1:0]} : (s2_sum[SIG_W-1:0] << lzc);
    exp_x    = XE_W'(s2_exp) + XE_W'(carry) - (carry ? '0 : XE_W'(lzc));
    m        = norm[SIG_W-1:3];
    g_bit    = norm[2];
    r_bit    = norm[1];
    s_bit    = norm[0];
    rnd_up   = g_bit & (r_bit | s_bit | m[0]);
    m_r      = {1'b0, m} + (MAN_W+2)'(rnd_up);
    exp_r    = exp_x + XE_W'(m_r[MAN_W+1]);
    uf       = exp_r[XE_W-1] || (exp_r == '0);
    of       = !uf && (exp_r >= EXP_MAX);

    flags3 = '0;
    res3   = '0;
    if (s2_special) begin
      res3   = s2_spec_val;
      flags3 = s2_spec_flags;
    end else if (sum_zero) begin
      res3 = {s2_sign & ~s2_eff_sub, (W-1)'(0)};
    end else if (uf) begin
      res3                   = {s2_sign, (W-1)'(0)};
      flags3[FLAG_UNDERFLOW] = 1'b1;
      flags3[FLAG_INEXACT]   = 1'b1;
    end else if (of) begin
      res3                  = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags3[FLAG_OVERFLOW] = 1'b1;
      flags3[FLAG_INEXACT]  = 1'b1;
    end else begin
      res3                 = {s2_sign, exp_r[EXP_W-1:0], m_r[MAN_W-1:0]};
      flags3[FLAG_INEXACT] = g_bit | r_bit | s_bit;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.flags     <= '0;
      bus.Exception <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= s2_valid;
      bus.result    <= res3;
      bus.flags     <= flags3;
      bus.Exception <= |flags3;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed-vector bench for fp_addsub_pipe in single precision.
module tb_fp_addsub_pipe;
  import fp_pkg::*;

  localparam int unsigned EW = EXP_W_DEF;
  localparam int unsigned MW = MAN_W_DEF;
  localparam int unsigned W  = 1 + EW + MW;
  localparam int NVEC = 16;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  fp_addsub_pipe_if #(.W(W)) bus ();

  fp_addsub_pipe #(.EXP_W(EW), .MAN_W(MW)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  vec_t vecs[NVEC];
  logic [31:0] q[$];
  bit collect = 1'b0;

  always @(negedge CLK) begin
    if (collect && bus.out_valid && bus.out_ready) q.push_back(bus.result);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic drive(input int i);
    bus.in_valid   = 1'b1;
    bus.a_operand  = vecs[i].a;
    bus.b_operand  = vecs[i].b;
    bus.AddBar_Sub = vecs[i].sub;
  endtask

  task automatic run_one(input int i);
    int lat;
    drive(i);
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
    check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    check($sformatf("vec%0d_result", i), bus.result, vecs[i].res);
    check($sformatf("vec%0d_flags", i), 32'(bus.flags), 32'(vecs[i].flg));
    check($sformatf("vec%0d_exception", i), 32'(bus.Exception), 32'(|vecs[i].flg));
    @(posedge CLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx, cyc, n;
    bit acc, ghost;

    // flags = {invalid, overflow, underflow, inexact}
    vecs[0]  = '{32'h40A00000, 32'h40A00000, 1'b0, 32'h41200000, 4'b0000};
    vecs[1]  = '{32'h40A00000, 32'h40A00000, 1'b1, 32'h00000000, 4'b0000};
    vecs[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
    vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
    vecs[4]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
    vecs[5]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
    vecs[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
    vecs[7]  = '{32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011};
    vecs[8]  = '{32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 4'b0000};
    vecs[9]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
    vecs[10] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000};
    vecs[11] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000};
    vecs[12] = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
    vecs[13] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001};
    vecs[14] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000};
    vecs[15] = '{32'h3F800000, 32'h33000000, 1'b1, 32'h3F800000, 4'b0001};

    RESET_N        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.a_operand  = '0;
    bus.b_operand  = '0;
    bus.AddBar_Sub = 1'b0;
    bus.out_ready  = 1'b1;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    check("rst_exception", 32'(bus.Exception), 32'd0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < NVEC; i++) run_one(i);

    // Back-to-back stream with out_ready dropped for two cycles.
    q.delete();
    collect = 1'b1;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 60) begin
      bus.out_ready = !(cyc == 4 || cyc == 5);
      drive(idx);
      #1;
      if (cyc == 4 || cyc == 5) check($sformatf("stall_in_ready_c%0d", cyc), 32'(bus.in_ready), 32'd0);
      acc = bus.in_ready;
      @(posedge CLK); #1;
      if (acc) idx++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (q.size() < 8 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    repeat (4) @(posedge CLK);
    #1;
    collect = 1'b0;
    check("stream_count", 32'(q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("stream_res%0d", i), (i < q.size()) ? q[i] : 32'hxxxxxxxx, vecs[i].res);
    end

    // Reset with three operations in flight.
    for (int k = 0; k < 3; k++) begin
      drive(k);
      @(posedge CLK); #1;
    end
    bus.in_valid = 1'b0;
    check("inflight_out_valid_before", 32'(bus.out_valid), 32'd1);
    RESET_N = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    check("midrst_flags", 32'(bus.flags), 32'd0);
    @(posedge CLK); #3;
    RESET_N = 1'b1;
    ghost = 1'b0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (bus.out_valid) ghost = 1'b1;
    end
    check("postrst_no_ghost", 32'(ghost), 32'd0);
    check("postrst_in_ready", 32'(bus.in_ready), 32'd1);
    run_one(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
